// File: rtl/pkt_defs_pkg.sv
// -----------------------------------------------------------------------------
// pkt_defs_pkg
// Definitions shared by the transmit serializer and the node-info receive path:
// stream/field widths, packet type codes, per-type word counts, the field
// selector used to pick latched node state, and the serializer FSM states.
// -----------------------------------------------------------------------------
package pkt_defs_pkg;

  localparam int MEM_WIDTH  = 8;   // byte width of the packet stream
  localparam int WORD_WIDTH = 16;  // width of every packet field

  // Word count fits in 3 bits (largest packet carries 4 words).
  localparam int WCNT_W = 3;

  typedef enum logic [2:0] {
    PKT_HB   = 3'b000,
    PKT_CHE  = 3'b001,
    PKT_INV  = 3'b010,
    PKT_CHTS = 3'b100,
    PKT_DATA = 3'b101
  } pkt_type_e;

  localparam logic [WCNT_W-1:0] N_HB   = 3'd4;
  localparam logic [WCNT_W-1:0] N_CHE  = 3'd2;
  localparam logic [WCNT_W-1:0] N_INV  = 3'd3;
  localparam logic [WCNT_W-1:0] N_CHTS = 3'd4;
  localparam logic [WCNT_W-1:0] N_DATA = 3'd4;

  // Index into the latched field bank; order matches the bank packing.
  typedef enum logic [2:0] {
    FLD_NODE_ID  = 3'd0,
    FLD_HOPS     = 3'd1,
    FLD_ENERGY   = 3'd2,
    FLD_THRESH   = 3'd3,
    FLD_QVALUE   = 3'd4,
    FLD_DEST     = 3'd5,
    FLD_TIMESLOT = 3'd6,
    FLD_DATA     = 3'd7
  } field_sel_e;

  localparam int NUM_FIELDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_BODY = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5
  } tx_state_e;

endpackage

// File: rtl/pkt_layout.sv
// -----------------------------------------------------------------------------
// pkt_layout
// Combinational packet layout table. For a packet type and body word index it
// returns which node field occupies that word, the packet's word count, and
// whether the type code is one the node can transmit.
//
// Ports:
//   pkt_type  in   3-bit type code (may be an unsupported code)
//   word_idx  in   body word index, 0..N-1
//   word_cnt  out  number of body words N (0 for unsupported codes)
//   field_sel out  field carried by body word word_idx
//   type_ok   out  type code is HB, CHE, INV, CHTimeslot or Data
// -----------------------------------------------------------------------------
module pkt_layout
  import pkt_defs_pkg::*;
(
  input  logic [2:0]        pkt_type,
  input  logic [1:0]        word_idx,
  output logic [WCNT_W-1:0] word_cnt,
  output field_sel_e        field_sel,
  output logic              type_ok
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis infers latches.
  always_comb begin
    word_cnt  = '0;
    field_sel = FLD_NODE_ID;
    type_ok   = 1'b0;
    case (pkt_type)
      PKT_HB: begin
        type_ok  = 1'b1;
        word_cnt = N_HB;
        case (word_idx)
          2'd0:    field_sel = FLD_NODE_ID;
          2'd1:    field_sel = FLD_HOPS;
          2'd2:    field_sel = FLD_ENERGY;
          default: field_sel = FLD_THRESH;
        endcase
      end
      PKT_CHE: begin
        type_ok  = 1'b1;
        word_cnt = N_CHE;
        field_sel = (word_idx == 2'd0) ? FLD_NODE_ID : FLD_DEST;
      end
      PKT_INV: begin
        type_ok  = 1'b1;
        word_cnt = N_INV;
        case (word_idx)
          2'd0:    field_sel = FLD_NODE_ID;
          2'd1:    field_sel = FLD_HOPS;
          default: field_sel = FLD_QVALUE;
        endcase
      end
      PKT_CHTS: begin
        type_ok  = 1'b1;
        word_cnt = N_CHTS;
        case (word_idx)
          2'd0:    field_sel = FLD_NODE_ID;
          2'd1:    field_sel = FLD_DEST;
          2'd2:    field_sel = FLD_HOPS;
          default: field_sel = FLD_TIMESLOT;
        endcase
      end
      PKT_DATA: begin
        type_ok  = 1'b1;
        word_cnt = N_DATA;
        case (word_idx)
          2'd0:    field_sel = FLD_NODE_ID;
          2'd1:    field_sel = FLD_DEST;
          2'd2:    field_sel = FLD_HOPS;
          default: field_sel = FLD_DATA;
        endcase
      end
      default: ;  // unsupported codes keep the defaults (type_ok = 0)
    endcase
  end

endmodule

// File: rtl/pkt_transmitter.sv
// -----------------------------------------------------------------------------
// pkt_transmitter
// Transmit-side packet serializer. A start strobe in IDLE latches the packet
// type and all node fields, then the packet is streamed one byte per accepted
// handshake:  {0,type}, N, N words MSB-first, XOR checksum of prior bytes.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   en_PT, fPktType      start strobe and packet type (sampled in IDLE only)
//   myNodeID .. dataWord node field sources, latched at start
//   tx_data, tx_valid    byte stream toward the radio/TX buffer
//   tx_ready             downstream accepts when tx_valid && tx_ready
//   busy                 packet in flight (HDR0 through CSUM)
//   done                 one-cycle pulse after the checksum byte is accepted
//   err                  one-cycle pulse after a start with an invalid type
//
// The hi/lo byte split assumes WORD_WIDTH == 2 * MEM_WIDTH.
// -----------------------------------------------------------------------------
module pkt_transmitter #(
  parameter int MEM_WIDTH  = pkt_defs_pkg::MEM_WIDTH,
  parameter int WORD_WIDTH = pkt_defs_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_PT,
  input  logic [2:0]            fPktType,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] hops,
  input  logic [WORD_WIDTH-1:0] energy,
  input  logic [WORD_WIDTH-1:0] e_threshold,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [WORD_WIDTH-1:0] timeslot,
  input  logic [WORD_WIDTH-1:0] dataWord,
  output logic [MEM_WIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import pkt_defs_pkg::*;

  tx_state_e state_q, state_d;

  logic [2:0]                            type_q;
  logic [NUM_FIELDS-1:0][WORD_WIDTH-1:0] fields_q, fields_d;
  logic [1:0]                            word_idx_q;
  logic                                  byte_lo_q;
  logic [MEM_WIDTH-1:0]                  csum_q;
  logic                                  err_q;

  logic                  start, start_bad, handshake;
  logic [2:0]            layout_type;
  logic [WCNT_W-1:0]     word_cnt;
  field_sel_e            field_sel;
  logic                  type_ok;
  logic [WORD_WIDTH-1:0] cur_word;
  logic                  last_word;

  // Field bank packed in field_sel_e order.
  always_comb begin
    fields_d               = '0;
    fields_d[FLD_NODE_ID]  = myNodeID;
    fields_d[FLD_HOPS]     = hops;
    fields_d[FLD_ENERGY]   = energy;
    fields_d[FLD_THRESH]   = e_threshold;
    fields_d[FLD_QVALUE]   = myQValue;
    fields_d[FLD_DEST]     = destinationID;
    fields_d[FLD_TIMESLOT] = timeslot;
    fields_d[FLD_DATA]     = dataWord;
  end

  // In IDLE the layout table validates the live type code; once a packet is
  // in flight it describes the latched type.
  assign layout_type = (state_q == ST_IDLE) ? fPktType : type_q;

  pkt_layout u_layout (
    .pkt_type  (layout_type),
    .word_idx  (word_idx_q),
    .word_cnt  (word_cnt),
    .field_sel (field_sel),
    .type_ok   (type_ok)
  );

  assign cur_word  = fields_q[field_sel];
  assign last_word = ({1'b0, word_idx_q} == (word_cnt - WCNT_W'(1)));
  assign handshake = tx_valid && tx_ready;

  // Next state and outputs. Outputs decode from the registered state so they
  // hold steady through a stall and fall to zero as soon as reset asserts.
  always_comb begin
    state_d   = state_q;
    tx_valid  = 1'b0;
    tx_data   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    start     = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_PT) begin
          if (type_ok) begin
            start   = 1'b1;
            state_d = ST_HDR0;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_HDR0: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = MEM_WIDTH'(type_q);
        if (handshake) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = MEM_WIDTH'(word_cnt);
        if (handshake) state_d = ST_BODY;
      end
      ST_BODY: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = byte_lo_q ? cur_word[MEM_WIDTH-1:0]
                             : cur_word[WORD_WIDTH-1 -: MEM_WIDTH];
        if (handshake && byte_lo_q && last_word) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = csum_q;
        if (handshake) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the latched field bank is reset along with the control state; it is
  // small flop storage, not a RAM, so the reset costs nothing meaningful and
  // keeps every visible value defined after an abort.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      type_q     <= '0;
      fields_q   <= '0;
      word_idx_q <= '0;
      byte_lo_q  <= 1'b0;
      csum_q     <= '0;
    end else if (start) begin
      type_q     <= fPktType;
      fields_q   <= fields_d;
      word_idx_q <= '0;
      byte_lo_q  <= 1'b0;
      csum_q     <= '0;
    end else if (handshake) begin
      // The checksum byte itself is not folded into the running XOR.
      if (state_q != ST_CSUM) csum_q <= csum_q ^ tx_data;
      if (state_q == ST_BODY) begin
        byte_lo_q <= ~byte_lo_q;
        if (byte_lo_q) word_idx_q <= word_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err_q <= 1'b0;
    else       err_q <= start_bad;
  end

  assign err = err_q;

endmodule

// File: tb/tb_pkt_transmitter.sv
// -----------------------------------------------------------------------------
// tb_pkt_transmitter
// Directed bench for pkt_transmitter. Stimulus pushes the hand-computed bytes
// of each packet into a scoreboard queue; an independent monitor pops and
// compares on every accepted byte and checks stall stability.
// -----------------------------------------------------------------------------
module tb_pkt_transmitter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en_PT = 1'b0;
  logic [2:0]  fPktType = 3'b000;
  logic [15:0] myNodeID, hops, energy, e_threshold;
  logic [15:0] myQValue, destinationID, timeslot, dataWord;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, done, err;

  pkt_transmitter dut (
    .clk           (clk),
    .nrst          (nrst),
    .en_PT         (en_PT),
    .fPktType      (fPktType),
    .myNodeID      (myNodeID),
    .hops          (hops),
    .energy        (energy),
    .e_threshold   (e_threshold),
    .myQValue      (myQValue),
    .destinationID (destinationID),
    .timeslot      (timeslot),
    .dataWord      (dataWord),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] sb[$];

  logic [7:0] hb_bytes   [11];
  logic [7:0] che_bytes  [7];
  logic [7:0] chts_bytes [11];
  logic [7:0] inv_bytes  [9];
  logic [7:0] data_bytes [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted byte against the scoreboard head and
  // check that a stalled byte is held unchanged.
  logic       prev_stall;
  logic [7:0] prev_data;
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", tx_valid, 1);
          check("stall_data_held", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
          end else begin
            check("stream_byte", tx_data, sb.pop_front());
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Backpressure generator: tx_ready two cycles high, two cycles low.
  logic bp_mode = 1'b0;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        cnt++;
        tx_ready = cnt[1];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic start_pkt(input logic [2:0] t);
    @(posedge clk);
    #1;
    en_PT    = 1'b1;
    fPktType = t;
    @(posedge clk);
    #1;
    en_PT = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, got, 1);
    if (got) begin
      check({name, "_busy_in_done"}, busy, 0);
      check({name, "_valid_in_done"}, tx_valid, 0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, done, 0);
    end
    check({name, "_all_bytes_sent"}, sb.size(), 0);
  endtask

  initial begin
    logic any_flag;

    hb_bytes   = '{8'h00, 8'h04, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h80, 8'h00, 8'h33, 8'h33, 8'h89};
    che_bytes  = '{8'h01, 8'h02, 8'h00, 8'h0C, 8'h00, 8'h20, 8'h2F};
    chts_bytes = '{8'h04, 8'h04, 8'h00, 8'h0C, 8'h00, 8'h20, 8'h00, 8'h01, 8'h00, 8'h05, 8'h28};
    inv_bytes  = '{8'h02, 8'h03, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h40, 8'h00, 8'h4C};
    data_bytes = '{8'h05, 8'h04, 8'h00, 8'h0C, 8'h00, 8'h20, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h7D};

    myNodeID      = 16'h000C;
    hops          = 16'h0001;
    energy        = 16'h8000;
    e_threshold   = 16'h3333;
    myQValue      = 16'h0000;
    destinationID = 16'h0000;
    timeslot      = 16'h0000;
    dataWord      = 16'h0000;

    // Reset state
    #1;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    // HB, continuous ready
    foreach (hb_bytes[i]) sb.push_back(hb_bytes[i]);
    start_pkt(3'b000);
    check("hb_valid_after_start", tx_valid, 1);
    check("hb_busy_after_start", busy, 1);
    check("hb_first_byte", tx_data, 8'h00);
    wait_done("hb");

    // CHE, inputs disturbed after start
    destinationID = 16'h0020;
    foreach (che_bytes[i]) sb.push_back(che_bytes[i]);
    start_pkt(3'b001);
    myNodeID      = 16'hFFFF;
    destinationID = 16'hAAAA;
    fPktType      = 3'b010;
    wait_done("che");
    myNodeID = 16'h000C;
    destinationID = 16'h0020;

    // HB under backpressure
    foreach (hb_bytes[i]) sb.push_back(hb_bytes[i]);
    bp_mode = 1'b1;
    start_pkt(3'b000);
    wait_done("hb_bp");
    bp_mode = 1'b0;
    @(posedge clk);
    #1;
    tx_ready = 1'b1;

    // Invalid type
    start_pkt(3'b111);
    check("inv_type_err", err, 1);
    check("inv_type_valid", tx_valid, 0);
    check("inv_type_busy", busy, 0);
    @(posedge clk);
    #1;
    check("inv_type_err_pulse", err, 0);
    check("inv_type_valid_after", tx_valid, 0);
    check("inv_type_busy_after", busy, 0);

    // CHTimeslot with a second strobe mid-packet
    timeslot = 16'h0005;
    foreach (chts_bytes[i]) sb.push_back(chts_bytes[i]);
    start_pkt(3'b100);
    repeat (3) @(posedge clk);
    #1;
    en_PT    = 1'b1;
    fPktType = 3'b000;
    @(posedge clk);
    #1;
    en_PT = 1'b0;
    wait_done("chts");
    any_flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid) any_flag = 1'b1;
    end
    check("chts_no_second_pkt", any_flag, 0);

    // Reset during BODY
    foreach (hb_bytes[i]) sb.push_back(hb_bytes[i]);
    start_pkt(3'b000);
    repeat (4) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    any_flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || tx_valid) any_flag = 1'b1;
    end
    check("abort_no_done", any_flag, 0);

    // INV after the abort
    myQValue = 16'h4000;
    foreach (inv_bytes[i]) sb.push_back(inv_bytes[i]);
    start_pkt(3'b010);
    wait_done("inv");

    // Data
    dataWord = 16'hBEEF;
    foreach (data_bytes[i]) sb.push_back(data_bytes[i]);
    start_pkt(3'b101);
    wait_done("data");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
